uart_tx_word_serializer: RTL



---
 rtl/shared_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/uart_tx_word_serializer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shared_pkg.sv
// Shared UART-side types and constants for the APB/AES to UART bridge.
// Pure declarations: no latency, no flow control.
// Imported by the serializer and its baud generator.
package shared_pkg;

    typedef enum logic [1:0] {
        IDLE_U,
        START_U,
        DATA_U,
        STOP_U
    } uart_state_e;

    typedef enum logic {
        PATH_APB,
        PATH_AES
    } uart_path_e;

    localparam int NBYTES          = 4;
    localparam int UART_OVERSAMPLE = 16;
    // 500 MHz / (16 * 9600), truncated to an integer divider
    localparam int CLKS_PER_TICK   = 3255;

    // Counter width that stays legal (>= 1 bit) for degenerate counts
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every CLKS_PER_TICK clocks.
// Tick asserted combinationally from the counter state; counter restarts on clr.
// No backpressure: free-running.
module uart_baud_gen
    import shared_pkg::*;
#(
    parameter int CLKS_PER_TICK = shared_pkg::CLKS_PER_TICK
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK) begin
        if (!PRESETn || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Word-to-UART serializer: DATA_WIDTH word out as 8N1 frames, LS byte first.
// Latency: tx_o falls at the accept edge; word_done_o after NBYTES*10*BIT_CYCLES.
// Backpressure: tx_ready_o only high while idle; valid without ready is dropped.
module uart_tx_word_serializer
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH    = NBYTES * 8,
    parameter int CLKS_PER_TICK = shared_pkg::CLKS_PER_TICK,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [DATA_WIDTH-1:0] tx_word_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  word_done_o
);

    localparam int            NB      = DATA_WIDTH / 8;
    localparam int            BW      = cnt_width(NB);
    localparam int            OW      = cnt_width(OVERSAMPLE);
    localparam logic [OW-1:0] OS_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BY_LAST = BW'(NB - 1);

    uart_state_e           state;
    logic [DATA_WIDTH-1:0] word_q;
    logic [BW-1:0]         byte_idx;
    logic [2:0]            bit_idx;
    logic [2:0]            next_bit;
    logic [OW-1:0]         os_cnt;
    logic [7:0]            cur_byte;
    logic                  tick;
    logic                  accept;
    logic                  bit_end;

    assign accept   = tx_valid_i && tx_ready_o;
    assign bit_end  = tick && (os_cnt == OS_LAST);
    assign cur_byte = word_q[{byte_idx, 3'b000} +: 8];
    assign next_bit = bit_idx + 3'd1;

    // Restarting the divider on accept aligns every bit boundary to the accept edge
    uart_baud_gen #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_baud_gen (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (accept),
        .tick    (tick)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE_U;
            tx_o        <= 1'b1;
            tx_ready_o  <= 1'b0;
            busy_o      <= 1'b0;
            word_done_o <= 1'b0;
            word_q      <= '0;
            byte_idx    <= '0;
            bit_idx     <= '0;
            os_cnt      <= '0;
        end else begin
            word_done_o <= 1'b0;
            if (state != IDLE_U && tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
            end

            case (state)
                IDLE_U: begin
                    tx_ready_o <= 1'b1;
                    tx_o       <= 1'b1;
                    busy_o     <= 1'b0;
                    if (accept) begin
                        word_q     <= tx_word_i;
                        byte_idx   <= '0;
                        bit_idx    <= '0;
                        os_cnt     <= '0;
                        state      <= START_U;
                        tx_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        tx_o       <= 1'b0;
                    end
                end

                START_U: begin
                    if (bit_end) begin
                        state <= DATA_U;
                        tx_o  <= cur_byte[bit_idx];
                    end
                end

                DATA_U: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP_U;
                            bit_idx <= '0;
                            tx_o    <= 1'b1;
                        end else begin
                            bit_idx <= next_bit;
                            tx_o    <= cur_byte[next_bit];
                        end
                    end
                end

                STOP_U: begin
                    if (bit_end) begin
                        if (byte_idx == BY_LAST) begin
                            state       <= IDLE_U;
                            byte_idx    <= '0;
                            tx_ready_o  <= 1'b1;
                            busy_o      <= 1'b0;
                            word_done_o <= 1'b1;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap
                            state    <= START_U;
                            byte_idx <= byte_idx + BW'(1);
                            tx_o     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE_U;
                    tx_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule
